// File: rtl/pds_port_seq.sv
// Power-switch sequencer: staggers port turn-on through one shared inrush slot,
// qualifies power-good and converts debounced overcurrent into a timed off request.
module pds_port_seq #(
  parameter int NUM_PORTS  = 4,
  parameter int INRUSH_CYC = 16,
  parameter int FAULT_CYC  = 4,
  parameter int RETRY_CYC  = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_PORTS-1:0] on,
  input  logic [NUM_PORTS-1:0] oc,
  output logic [NUM_PORTS-1:0] gate_en,
  output logic [NUM_PORTS-1:0] pwr_good,
  output logic [NUM_PORTS-1:0] off,
  output logic                 busy
);

  localparam int RAMP_W = $clog2(INRUSH_CYC);
  localparam int DBC_W  = $clog2(FAULT_CYC + 1);
  localparam int COOL_W = $clog2(RETRY_CYC + 1);
  localparam logic [RAMP_W-1:0] RAMP_LAST  = RAMP_W'(INRUSH_CYC - 1);
  localparam logic [DBC_W-1:0]  FAULT_LAST = DBC_W'(FAULT_CYC - 1);
  localparam logic [COOL_W-1:0] COOL_LAST  = COOL_W'(RETRY_CYC - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_RAMP, ST_ON, ST_FAULT} state_t;

  logic [NUM_PORTS-1:0] in_ramp;
  logic [NUM_PORTS-1:0] ramp_exit;
  logic [NUM_PORTS-1:0] want;
  logic [NUM_PORTS-1:0] grant;
  logic [RAMP_W-1:0]    ramp_cnt_reg;
  logic                 ramp_done;
  logic                 slot_free;
  logic                 busy_reg;

  assign ramp_done = (ramp_cnt_reg == RAMP_LAST);
  // The slot counts as free on the same edge the current owner leaves RAMP.
  assign slot_free = ~|(in_ramp & ~ramp_exit);

  always_comb begin
    logic found;
    grant = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (slot_free && want[i] && !found) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ramp_cnt_reg <= '0;
      busy_reg     <= 1'b0;
    end else begin
      if (|(in_ramp & ~ramp_exit))
        ramp_cnt_reg <= ramp_cnt_reg + 1'b1;
      else
        ramp_cnt_reg <= '0;
      busy_reg <= |in_ramp;
    end
  end

  assign busy = busy_reg;

  generate
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
      state_t            state_reg;
      logic [DBC_W-1:0]  dbc_reg;
      logic [COOL_W-1:0] cool_reg;
      logic              gate_reg;
      logic              good_reg;
      logic              off_reg;

      assign in_ramp[gi]   = (state_reg == ST_RAMP);
      assign ramp_exit[gi] = in_ramp[gi] & (~on[gi] | ramp_done);
      assign want[gi]      = (state_reg == ST_IDLE) & on[gi];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          state_reg <= ST_IDLE;
          dbc_reg   <= '0;
          cool_reg  <= '0;
          gate_reg  <= 1'b0;
          good_reg  <= 1'b0;
          off_reg   <= 1'b0;
        end else begin
          case (state_reg)
            ST_IDLE: begin
              if (grant[gi]) state_reg <= ST_RAMP;
            end
            ST_RAMP: begin
              dbc_reg <= '0;
              if (!on[gi])        state_reg <= ST_IDLE;
              else if (ramp_done) state_reg <= ST_ON;
            end
            ST_ON: begin
              // Fault takes priority over a simultaneous disable.
              if (oc[gi] && dbc_reg == FAULT_LAST) begin
                state_reg <= ST_FAULT;
                dbc_reg   <= '0;
                cool_reg  <= '0;
              end else if (!on[gi]) begin
                state_reg <= ST_IDLE;
                dbc_reg   <= '0;
              end else if (oc[gi]) begin
                dbc_reg <= dbc_reg + 1'b1;
              end else begin
                dbc_reg <= '0;
              end
            end
            ST_FAULT: begin
              if (cool_reg == COOL_LAST) begin
                state_reg <= ST_IDLE;
                cool_reg  <= '0;
              end else begin
                cool_reg <= cool_reg + 1'b1;
              end
            end
            default: state_reg <= ST_IDLE;
          endcase
          gate_reg <= (state_reg == ST_RAMP) || (state_reg == ST_ON);
          good_reg <= (state_reg == ST_ON);
          off_reg  <= (state_reg == ST_FAULT);
        end
      end

      assign gate_en[gi]  = gate_reg;
      assign pwr_good[gi] = good_reg;
      assign off[gi]      = off_reg;
    end
  endgenerate

endmodule

// File: tb/tb_pds_port_seq.sv
// Bench for pds_port_seq: hand-derived vector table, corner-case sequences and
// randomized traffic against a per-port timer model.
module tb_pds_port_seq;

  localparam int NP = 4;
  localparam int INRUSH = 16;
  localparam int FAULTN = 4;
  localparam int RETRY = 64;
  localparam int M_IDLE = 0, M_RAMP = 1, M_ON = 2, M_FAULT = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NP-1:0] on = '0;
  logic [NP-1:0] oc = '0;
  logic [NP-1:0] gate_en, pwr_good, off;
  logic          busy;

  int checks = 0;
  int passes = 0;

  pds_port_seq #(.NUM_PORTS(NP), .INRUSH_CYC(INRUSH), .FAULT_CYC(FAULTN), .RETRY_CYC(RETRY)) dut (
    .clk(clk), .rst(rst), .on(on), .oc(oc),
    .gate_en(gate_en), .pwr_good(pwr_good), .off(off), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else passes++;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference model: each port has a mode plus countdown timers; outputs
  // lag the mode by one clock.
  int mode [NP];
  int run_len [NP];
  int cool_left [NP];
  int ramp_left;
  logic [NP-1:0] exp_g, exp_p, exp_o;
  logic exp_b;

  task model_step();
    int  owner;
    bit  free;
    int  nm [NP];
    exp_g = '0; exp_p = '0; exp_o = '0; exp_b = 1'b0;
    owner = -1;
    for (int i = 0; i < NP; i++) begin
      nm[i] = mode[i];
      exp_g[i] = (mode[i] == M_RAMP) || (mode[i] == M_ON);
      exp_p[i] = (mode[i] == M_ON);
      exp_o[i] = (mode[i] == M_FAULT);
      if (mode[i] == M_RAMP) begin exp_b = 1'b1; owner = i; end
    end
    free = (owner < 0);
    if (owner >= 0) begin
      if (!on[owner]) begin nm[owner] = M_IDLE; free = 1; end
      else if (ramp_left == 1) begin nm[owner] = M_ON; run_len[owner] = 0; free = 1; end
      else ramp_left--;
    end
    for (int i = 0; i < NP; i++) begin
      if (mode[i] == M_ON) begin
        run_len[i] = oc[i] ? run_len[i] + 1 : 0;
        if (run_len[i] >= FAULTN) begin nm[i] = M_FAULT; cool_left[i] = RETRY; end
        else if (!on[i]) nm[i] = M_IDLE;
      end else if (mode[i] == M_FAULT) begin
        if (cool_left[i] == 1) nm[i] = M_IDLE;
        else cool_left[i]--;
      end else if (mode[i] == M_IDLE && on[i] && free) begin
        nm[i] = M_RAMP; ramp_left = INRUSH; free = 0;
      end
    end
    for (int i = 0; i < NP; i++) mode[i] = nm[i];
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NP; i++) begin mode[i] = M_IDLE; run_len[i] = 0; cool_left[i] = 0; end
      ramp_left = 0;
      exp_g = '0; exp_p = '0; exp_o = '0; exp_b = 1'b0;
    end else begin
      model_step();
    end
  end

  always @(negedge clk) begin
    chk("model_outputs", {gate_en, pwr_good, off, busy}, {exp_g, exp_p, exp_o, exp_b});
    chk("one_port_ramping", 32'($onehot0(gate_en & ~pwr_good)), 32'd1);
    chk("good_implies_gate", pwr_good & ~gate_en, 0);
    chk("off_implies_no_gate", off & gate_en, 0);
  end

  typedef struct {
    int          n;
    logic [NP-1:0] on_v;
    logic [NP-1:0] oc_v;
    logic [NP-1:0] g;
    logic [NP-1:0] p;
    logic [NP-1:0] o;
    logic        b;
  } vec_t;

  vec_t tbl [$];

  initial begin
    // Single port then three-way contention, expectations after the last edge of each run.
    tbl.push_back('{1,  4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0});
    tbl.push_back('{1,  4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 1'b1});
    tbl.push_back('{15, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 1'b1});
    tbl.push_back('{1,  4'b0001, 4'b0000, 4'b0001, 4'b0001, 4'b0000, 1'b0});
    tbl.push_back('{1,  4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0000, 1'b0});
    tbl.push_back('{1,  4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0});
    tbl.push_back('{1,  4'b1011, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0});
    tbl.push_back('{1,  4'b1011, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 1'b1});
    tbl.push_back('{15, 4'b1011, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 1'b1});
    tbl.push_back('{1,  4'b1011, 4'b0000, 4'b0011, 4'b0001, 4'b0000, 1'b1});
    tbl.push_back('{15, 4'b1011, 4'b0000, 4'b0011, 4'b0001, 4'b0000, 1'b1});
    tbl.push_back('{1,  4'b1011, 4'b0000, 4'b1011, 4'b0011, 4'b0000, 1'b1});
    tbl.push_back('{15, 4'b1011, 4'b0000, 4'b1011, 4'b0011, 4'b0000, 1'b1});
    tbl.push_back('{1,  4'b1011, 4'b0000, 4'b1011, 4'b1011, 4'b0000, 1'b0});
    tbl.push_back('{1,  4'b0000, 4'b0000, 4'b1011, 4'b1011, 4'b0000, 1'b0});
    tbl.push_back('{1,  4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0});

    rst = 1'b1; on = '0; oc = '0;
    #2;
    chk("reset_async_outputs", {gate_en, pwr_good, off, busy}, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_gate", gate_en, 0);
    chk("reset_good", pwr_good, 0);
    chk("reset_off", off, 0);
    chk("reset_busy", busy, 0);

    for (int k = 0; k < tbl.size(); k++) begin
      on = tbl[k].on_v; oc = tbl[k].oc_v;
      tick(tbl[k].n);
      chk($sformatf("vec%0d_gate", k), gate_en, tbl[k].g);
      chk($sformatf("vec%0d_good", k), pwr_good, tbl[k].p);
      chk($sformatf("vec%0d_off", k), off, tbl[k].o);
      chk($sformatf("vec%0d_busy", k), busy, tbl[k].b);
    end

    // Debounce, fault cooldown and retry on port 2.
    on = 4'b0100; tick(18);
    chk("p2_on_good", pwr_good, 4'b0100);
    oc = 4'b0100; tick(3); oc = '0; tick(1);
    oc = 4'b0100; tick(3); oc = '0; tick(2);
    chk("p2_short_oc_no_fault_off", off, 0);
    chk("p2_short_oc_still_good", pwr_good, 4'b0100);
    oc = 4'b0100; tick(4);
    chk("p2_fault_edge_still_good", pwr_good, 4'b0100);
    oc = '0; tick(1);
    chk("p2_fault_off", off, 4'b0100);
    chk("p2_fault_gate", gate_en, 0);
    chk("p2_fault_good", pwr_good, 0);
    tick(63);
    chk("p2_cooldown_last_off", off, 4'b0100);
    tick(1);
    chk("p2_cooldown_done_off", off, 0);
    chk("p2_idle_gate", gate_en, 0);
    tick(1);
    chk("p2_retry_gate", gate_en, 4'b0100);
    chk("p2_retry_busy", busy, 1'b1);
    tick(15);
    chk("p2_retry_not_good_yet", pwr_good, 0);
    tick(1);
    chk("p2_retry_good", pwr_good, 4'b0100);
    on = '0; tick(2);

    // Abort port 1 at ramp count 7 while port 3 waits.
    on = 4'b1010; tick(8);
    on = 4'b1000; tick(1);
    chk("abort_edge_gate", gate_en, 4'b0010);
    tick(1);
    chk("abort_handoff_gate", gate_en, 4'b1000);
    chk("abort_handoff_busy", busy, 1'b1);
    tick(15);
    chk("p3_not_good_yet", pwr_good, 0);
    tick(1);
    chk("p3_good", pwr_good, 4'b1000);
    on = '0; tick(2);

    // Fourth overcurrent cycle coincides with on dropping.
    on = 4'b0001; tick(18);
    oc = 4'b0001; tick(3);
    on = '0; tick(1);
    oc = '0; tick(1);
    chk("simul_fault_off", off, 4'b0001);
    chk("simul_fault_gate", gate_en, 0);
    tick(63);
    chk("simul_cool_off", off, 4'b0001);
    tick(1);
    chk("simul_cool_done", off, 0);

    // Async reset with port 0 ramping and port 2 cooling down.
    on = 4'b0100; tick(18);
    oc = 4'b0100; tick(4);
    oc = '0; on = 4'b0101; tick(3);
    chk("pre_reset_gate", gate_en, 4'b0001);
    chk("pre_reset_off", off, 4'b0100);
    chk("pre_reset_busy", busy, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("midop_reset_outputs", {gate_en, pwr_good, off, busy}, 0);
    @(posedge clk); #1 rst = 1'b0;
    tick(1);
    chk("post_reset_gate0", gate_en, 0);
    tick(1);
    chk("post_reset_p0_first", gate_en, 4'b0001);
    tick(16);
    chk("post_reset_gate", gate_en, 4'b0101);
    chk("post_reset_good", pwr_good, 4'b0001);
    on = '0; tick(2);

    // Randomized traffic; the negedge monitor compares against the model.
    for (int c = 0; c < 4000; c++) begin
      int idx;
      if ($urandom_range(0, 15) == 0) begin
        idx = $urandom_range(0, NP - 1);
        on[idx] = ~on[idx];
      end
      for (int i = 0; i < NP; i++) oc[i] = ($urandom_range(0, 99) < 35);
      if ($urandom_range(0, 999) == 0) begin
        rst = 1'b1; #2 rst = 1'b0;
      end
      tick(1);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
